// File: rtl/bnn_ocr_pkg.sv
// Shared types and sizes for the OCR front end: byte width and image size.
package bnn_ocr_pkg;
  localparam int IMG_BYTES = 113;
  localparam int BYTE_W    = 8;
  typedef logic [BYTE_W-1:0] byte_t;
endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input, with one extra flop to
// detect rising/falling edges of the synchronised value.
module sync_edge_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic synced,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev   <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~prev;
  assign fall   = ~synced & prev;
endmodule

// File: rtl/spi_byte_receiver.sv
// SPI mode-0 peripheral: deserialises MOSI bytes into a one-entry valid/ready
// holding register, shifts a status byte out on MISO, flags dropped bytes.
module spi_byte_receiver
  import bnn_ocr_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sclk,
  input  logic               cs_n,
  input  logic               mosi,
  output logic               miso,
  input  logic               clear,
  input  logic [7:0]         status_in,
  output logic [7:0]         byte_out,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic               overflow,
  output logic               frame_active,
  output logic [COUNT_W-1:0] byte_count
);
  logic  sclk_s, sclk_rise, sclk_fall;
  logic  cs_s, cs_rise, cs_fall;
  logic  mosi_s;
  logic  [2:0] bit_cnt;
  byte_t rx_shift, tx_shift, new_byte;
  logic  complete, xfer;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .async_in(sclk),
    .synced(sclk_s), .rise(sclk_rise), .fall(sclk_fall));

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .async_in(cs_n),
    .synced(cs_s), .rise(cs_rise), .fall(cs_fall));

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .async_in(mosi),
    .synced(mosi_s), .rise(), .fall());

  assign frame_active = ~cs_s;
  assign miso         = frame_active & tx_shift[7];
  assign new_byte     = {rx_shift[6:0], mosi_s};
  assign complete     = frame_active & sclk_rise & (bit_cnt == 3'd7);
  assign xfer         = byte_valid & byte_ready;

  // Framing and shift registers; cs_n edges re-align the bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
    end else begin
      if (cs_fall) begin
        tx_shift <= status_in;
      end else if (frame_active) begin
        if (sclk_rise) rx_shift <= new_byte;
        if (complete)       tx_shift <= status_in;
        else if (sclk_fall) tx_shift <= {tx_shift[6:0], 1'b0};
      end
      if (clear || cs_fall || cs_rise) bit_cnt <= '0;
      else if (frame_active && sclk_rise) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Holding register: a completed byte lands only if the slot is free or
  // being emptied this cycle; otherwise it is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_out   <= '0;
      byte_valid <= 1'b0;
      overflow   <= 1'b0;
      byte_count <= '0;
    end else if (clear) begin
      byte_valid <= 1'b0;
      overflow   <= 1'b0;
      byte_count <= '0;
    end else begin
      if (complete && (!byte_valid || byte_ready)) begin
        byte_out   <= new_byte;
        byte_valid <= 1'b1;
      end else if (complete) begin
        overflow   <= 1'b1;
      end else if (xfer) begin
        byte_valid <= 1'b0;
      end
      if (xfer && byte_count != {COUNT_W{1'b1}})
        byte_count <= byte_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_byte_receiver.sv
// Bench for spi_byte_receiver: SPI host model, scoreboard queue of expected
// bytes popped on each valid/ready transfer.
module tb_spi_byte_receiver;
  localparam int HALF = 8;

  logic       clk = 0, rst_n = 0;
  logic       sclk = 0, cs_n = 1, mosi = 0, clear = 0, byte_ready = 0;
  logic [7:0] status_in = 0;
  logic       miso, byte_valid, overflow, frame_active;
  logic [7:0] byte_out;
  logic [6:0] byte_count;

  int         n_vec = 0, n_err = 0, vcyc = 0, n_xfer = 0;
  logic [7:0] exp_q[$];
  logic [7:0] so;

  spi_byte_receiver dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .clear(clear), .status_in(status_in), .byte_out(byte_out),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .overflow(overflow),
    .frame_active(frame_active), .byte_count(byte_count));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every transfer must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && byte_valid) begin
      vcyc++;
      if (byte_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) chk("unexpected_xfer", {24'd0, byte_out}, 32'hffff_ffff);
        else chk("xfer_byte", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic spi_byte(input logic [7:0] d, input int nbits, input bit pulse,
                          output logic [7:0] sout);
    sout = 0;
    for (int i = 0; i < nbits; i++) begin
      mosi = d[7-i];
      repeat (HALF) @(posedge clk);
      #1;
      sout = {sout[6:0], miso};
      sclk = 1;
      if (pulse && i == 7) begin
        // Raw rise lands in the DUT's completion cycle two edges later.
        repeat (2) @(posedge clk);
        #1 byte_ready = 1;
        @(posedge clk);
        #1 byte_ready = 0;
        repeat (HALF-3) @(posedge clk);
      end else begin
        repeat (HALF) @(posedge clk);
      end
      #1 sclk = 0;
    end
  endtask

  task automatic frame_start();
    @(posedge clk);
    #1 cs_n = 0;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic frame_end();
    repeat (HALF) @(posedge clk);
    #1 cs_n = 1;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1 clear = 1;
    @(posedge clk);
    #1 clear = 0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", byte_valid, 0);
    chk("rst_byte", byte_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_count", byte_count, 0);
    chk("rst_frame", frame_active, 0);
    chk("rst_miso", miso, 0);
    #1 rst_n = 1;

    // 1: single byte, consumer ready
    byte_ready = 1;
    vcyc = 0; n_xfer = 0;
    frame_start();
    chk("frame_active", frame_active, 1);
    exp_q.push_back(8'hA5);
    spi_byte(8'hA5, 8, 0, so);
    frame_end();
    chk("t1_byte", byte_out, 8'hA5);
    chk("t1_count", byte_count, 1);
    chk("t1_xfers", n_xfer, 1);
    chk("t1_valid_cycles", vcyc, 1);
    chk("t1_ovf", overflow, 0);
    chk("t1_frame_off", frame_active, 0);

    // 2: status byte on MISO
    status_in = 8'h3C;
    chk("t2_miso_idle", miso, 0);
    frame_start();
    exp_q.push_back(8'h55);
    spi_byte(8'h55, 8, 0, so);
    frame_end();
    chk("t2_miso_byte", so, 8'h3C);
    chk("t2_miso_cs_high", miso, 0);
    chk("t2_count", byte_count, 2);

    // 3: overflow with stalled consumer, then clear
    byte_ready = 0;
    frame_start();
    exp_q.push_back(8'h11);
    spi_byte(8'h11, 8, 0, so);
    spi_byte(8'h22, 8, 0, so);
    frame_end();
    chk("t3_valid", byte_valid, 1);
    chk("t3_byte", byte_out, 8'h11);
    chk("t3_ovf", overflow, 1);
    pulse_clear();
    exp_q.delete();
    chk("t3_clr_ovf", overflow, 0);
    chk("t3_clr_valid", byte_valid, 0);
    chk("t3_clr_count", byte_count, 0);

    // 4: ready pulsed exactly in the completion cycle of the second byte
    frame_start();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    spi_byte(8'h11, 8, 0, so);
    spi_byte(8'h22, 8, 1, so);
    frame_end();
    chk("t4_valid", byte_valid, 1);
    chk("t4_byte", byte_out, 8'h22);
    chk("t4_ovf", overflow, 0);
    chk("t4_count", byte_count, 1);
    #1 byte_ready = 1;
    repeat (3) @(negedge clk);
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_count2", byte_count, 2);

    // 5: aborted partial byte is discarded
    pulse_clear();
    frame_start();
    spi_byte(8'hFF, 5, 0, so);
    frame_end();
    frame_start();
    exp_q.push_back(8'h7E);
    spi_byte(8'h7E, 8, 0, so);
    frame_end();
    chk("t5_count", byte_count, 1);
    chk("t5_byte", byte_out, 8'h7E);
    chk("t5_ovf", overflow, 0);

    // 6: full image stream, then reset mid-byte
    pulse_clear();
    frame_start();
    for (int b = 0; b < 113; b++) begin
      exp_q.push_back(8'(b));
      spi_byte(8'(b), 8, 0, so);
    end
    frame_end();
    chk("t6_count", byte_count, 113);
    chk("t6_drained", exp_q.size(), 0);
    frame_start();
    spi_byte(8'hC3, 3, 0, so);
    #1 rst_n = 0;
    @(negedge clk);
    chk("t6_rst_valid", byte_valid, 0);
    chk("t6_rst_byte", byte_out, 0);
    chk("t6_rst_count", byte_count, 0);
    chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_frame", frame_active, 0);
    chk("t6_rst_miso", miso, 0);
    cs_n = 1;
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1 rst_n = 1;
    repeat (4) @(posedge clk);
    frame_start();
    exp_q.push_back(8'h5A);
    spi_byte(8'h5A, 8, 0, so);
    frame_end();
    chk("t6_after_byte", byte_out, 8'h5A);
    chk("t6_after_count", byte_count, 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
